// File: rtl/cache_line_transfer_if.sv
// Bus bundle for cache_line_transfer: command side (cache controller),
// higher-memory requester port and datalines-array port.
//   master : the transfer engine
//   slave  : the environment (controller, higher memory, line storage)
interface cache_line_transfer_if #(
  parameter int XLEN       = 32,
  parameter int LINE_SIZE  = 32,
  parameter int BEAT_WORDS = 1
);
  localparam int WSS = $clog2(LINE_SIZE / 4);
  localparam int DW  = BEAT_WORDS * XLEN;

  // command side
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_writeback;
  logic [XLEN-1:0] cmd_address;
  logic            busy;
  logic            done;
  logic            critical_valid;
  logic [XLEN-1:0] critical_word;
  // higher memory
  logic            hmem_req_valid;
  logic            hmem_req_write;
  logic [XLEN-1:0] hmem_req_address;
  logic [DW-1:0]   hmem_req_store_data;
  logic            hmem_req_fulfilled;
  logic [DW-1:0]   hmem_loaded_data;
  // line storage
  logic [WSS-1:0]  line_word_select;
  logic            line_write;
  logic [DW-1:0]   line_write_data;
  logic [DW-1:0]   line_read_data;

  modport master (
    input  cmd_valid, cmd_writeback, cmd_address,
           hmem_req_fulfilled, hmem_loaded_data, line_read_data,
    output cmd_ready, busy, done, critical_valid, critical_word,
           hmem_req_valid, hmem_req_write, hmem_req_address, hmem_req_store_data,
           line_word_select, line_write, line_write_data
  );

  modport slave (
    output cmd_valid, cmd_writeback, cmd_address,
           hmem_req_fulfilled, hmem_loaded_data, line_read_data,
    input  cmd_ready, busy, done, critical_valid, critical_word,
           hmem_req_valid, hmem_req_write, hmem_req_address, hmem_req_store_data,
           line_word_select, line_write, line_write_data
  );
endinterface

// File: rtl/cache_line_transfer.sv
// Cache line transfer engine: moves one full line between the datalines
// array and higher memory, either as a fill (miss) or a writeback (dirty
// victim). Beats are BEAT_WORDS words wide; with CRITICAL_FIRST the fill
// starts at the beat holding the requested word and wraps, and the requested
// word is flagged on critical_valid as it arrives (early restart).
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous, active-high; abandons any transfer in flight
//   bus   - cache_line_transfer_if.master (command, hmem, line ports)
module cache_line_transfer #(
  parameter int XLEN           = 32,
  parameter int LINE_SIZE      = 32,
  parameter int BEAT_WORDS     = 1,
  parameter int CRITICAL_FIRST = 1,
  parameter int READ_ONLY      = 0
) (
  input logic clk,
  input logic reset,
  cache_line_transfer_if.master bus
);
  localparam int WSS   = $clog2(LINE_SIZE / 4);
  localparam int BEATS = (LINE_SIZE / 4) / BEAT_WORDS;
  localparam int BSEL  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS   = $clog2(LINE_SIZE);
  localparam int BWB   = $clog2(BEAT_WORDS);

  if (XLEN != 32) begin : g_bad_xlen
    $error("cache_line_transfer: only XLEN=32 is supported");
  end
  if ((LINE_SIZE & (LINE_SIZE - 1)) != 0) begin : g_bad_line
    $error("cache_line_transfer: LINE_SIZE must be a power of 2");
  end
  if ((BEAT_WORDS & (BEAT_WORDS - 1)) != 0 || BEATS < 2) begin : g_bad_beat
    $error("cache_line_transfer: BEAT_WORDS must be a power of 2 leaving at least 2 beats");
  end

  typedef enum logic [1:0] {IDLE, FILL, WRITEBACK, DONE} state_t;

  state_t              state;
  logic [XLEN-OFS-1:0] block;
  logic [WSS-1:0]      crit_word;
  logic [BSEL-1:0]     beat;
  logic [BSEL:0]       remaining;

  logic [WSS-1:0]      cmd_word;
  logic [BSEL-1:0]     start_beat;
  logic [BSEL-1:0]     crit_beat;
  logic [WSS-1:0]      crit_idx;
  logic [WSS-1:0]      word_sel;
  logic                unused_addr_bits;

  assign cmd_word         = bus.cmd_address[OFS-1:2];
  assign unused_addr_bits = ^bus.cmd_address[1:0];
  assign start_beat       = (CRITICAL_FIRST != 0) ? BSEL'(cmd_word >> BWB) : '0;
  assign crit_beat        = BSEL'(crit_word >> BWB);
  assign crit_idx         = crit_word & WSS'(BEAT_WORDS - 1);
  assign word_sel         = WSS'(beat) << BWB;

  // Address, select and store data derive only from registered beat/block,
  // so they stay put across any number of stall cycles.
  assign bus.line_word_select    = word_sel;
  assign bus.hmem_req_address    = {block, word_sel, 2'b00};
  assign bus.hmem_req_store_data = bus.line_read_data;
  assign bus.line_write_data     = bus.hmem_loaded_data;

  // Same-cycle line write and early restart; gated on state so a fulfilled
  // seen outside a transfer (or during reset) has no effect.
  assign bus.line_write     = (state == FILL) && bus.hmem_req_fulfilled;
  assign bus.critical_valid = (state == FILL) && bus.hmem_req_fulfilled && (beat == crit_beat);
  assign bus.critical_word  = bus.critical_valid
                              ? bus.hmem_loaded_data[int'(crit_idx) * XLEN +: XLEN] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      block              <= '0;
      crit_word          <= '0;
      beat               <= '0;
      remaining          <= '0;
      bus.cmd_ready      <= 1'b1;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.hmem_req_valid <= 1'b0;
      bus.hmem_req_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            block         <= bus.cmd_address[XLEN-1:OFS];
            crit_word     <= cmd_word;
            beat          <= start_beat;
            remaining     <= (BSEL+1)'(BEATS);
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.cmd_writeback && READ_ONLY != 0) begin
              // no writeback path: acknowledge without memory traffic
              state    <= DONE;
              bus.done <= 1'b1;
            end else if (bus.cmd_writeback) begin
              state              <= WRITEBACK;
              bus.hmem_req_valid <= 1'b1;
              bus.hmem_req_write <= 1'b1;
            end else begin
              state              <= FILL;
              bus.hmem_req_valid <= 1'b1;
              bus.hmem_req_write <= 1'b0;
            end
          end
        end
        FILL, WRITEBACK: begin
          if (bus.hmem_req_fulfilled) begin
            beat      <= beat + 1'b1;  // power-of-2 beat count wraps naturally
            remaining <= remaining - 1'b1;
            // completion follows the count; the beat index may have wrapped
            if (remaining == (BSEL+1)'(1)) begin
              state              <= DONE;
              bus.done           <= 1'b1;
              bus.hmem_req_valid <= 1'b0;
              bus.hmem_req_write <= 1'b0;
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.done      <= 1'b0;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_line_transfer.sv
module tb_cache_line_transfer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sel;
  logic        cmd_valid, cmd_writeback, fulfilled;
  logic [31:0] cmd_address;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] line_word(logic [2:0] w);
    return 32'hA5A5_0000 + 32'(w) * 32'h111;
  endfunction

  // u0: BW2 critical-first; u1: BW2 in-order; u2: BW1; u3: BW1 read-only
  cache_line_transfer_if #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(2)) if0 ();
  cache_line_transfer_if #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(2)) if1 ();
  cache_line_transfer_if #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(1)) if2 ();
  cache_line_transfer_if #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(1)) if3 ();

  cache_line_transfer #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(2), .CRITICAL_FIRST(1), .READ_ONLY(0))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  cache_line_transfer #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(2), .CRITICAL_FIRST(0), .READ_ONLY(0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  cache_line_transfer #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(1), .CRITICAL_FIRST(1), .READ_ONLY(0))
    u2 (.clk(clk), .reset(reset), .bus(if2));
  cache_line_transfer #(.XLEN(32), .LINE_SIZE(32), .BEAT_WORDS(1), .CRITICAL_FIRST(1), .READ_ONLY(1))
    u3 (.clk(clk), .reset(reset), .bus(if3));

  assign if0.cmd_valid = cmd_valid && sel == 0;
  assign if1.cmd_valid = cmd_valid && sel == 1;
  assign if2.cmd_valid = cmd_valid && sel == 2;
  assign if3.cmd_valid = cmd_valid && sel == 3;
  assign if0.hmem_req_fulfilled = fulfilled && sel == 0;
  assign if1.hmem_req_fulfilled = fulfilled && sel == 1;
  assign if2.hmem_req_fulfilled = fulfilled && sel == 2;
  assign if3.hmem_req_fulfilled = fulfilled && sel == 3;
  assign if0.cmd_writeback = cmd_writeback;
  assign if1.cmd_writeback = cmd_writeback;
  assign if2.cmd_writeback = cmd_writeback;
  assign if3.cmd_writeback = cmd_writeback;
  assign if0.cmd_address = cmd_address;
  assign if1.cmd_address = cmd_address;
  assign if2.cmd_address = cmd_address;
  assign if3.cmd_address = cmd_address;

  // higher memory and line storage models
  assign if0.hmem_loaded_data = {mem_word(if0.hmem_req_address + 32'd4), mem_word(if0.hmem_req_address)};
  assign if1.hmem_loaded_data = {mem_word(if1.hmem_req_address + 32'd4), mem_word(if1.hmem_req_address)};
  assign if2.hmem_loaded_data = mem_word(if2.hmem_req_address);
  assign if3.hmem_loaded_data = mem_word(if3.hmem_req_address);
  assign if0.line_read_data = {line_word(if0.line_word_select + 3'd1), line_word(if0.line_word_select)};
  assign if1.line_read_data = {line_word(if1.line_word_select + 3'd1), line_word(if1.line_word_select)};
  assign if2.line_read_data = line_word(if2.line_word_select);
  assign if3.line_read_data = line_word(if3.line_word_select);

  // view of the currently selected instance
  logic        v_valid, v_wr, v_lw, v_cv, v_done;
  logic [31:0] v_addr, v_cw;
  logic [2:0]  v_wsel;
  logic [63:0] v_store, v_lwd;
  always_comb begin
    v_valid = if0.hmem_req_valid; v_wr = if0.hmem_req_write; v_lw = if0.line_write;
    v_cv = if0.critical_valid; v_done = if0.done; v_addr = if0.hmem_req_address;
    v_cw = if0.critical_word; v_wsel = if0.line_word_select;
    v_store = if0.hmem_req_store_data; v_lwd = if0.line_write_data;
    case (sel)
      1: begin
        v_valid = if1.hmem_req_valid; v_wr = if1.hmem_req_write; v_lw = if1.line_write;
        v_cv = if1.critical_valid; v_done = if1.done; v_addr = if1.hmem_req_address;
        v_cw = if1.critical_word; v_wsel = if1.line_word_select;
        v_store = if1.hmem_req_store_data; v_lwd = if1.line_write_data;
      end
      2: begin
        v_valid = if2.hmem_req_valid; v_wr = if2.hmem_req_write; v_lw = if2.line_write;
        v_cv = if2.critical_valid; v_done = if2.done; v_addr = if2.hmem_req_address;
        v_cw = if2.critical_word; v_wsel = if2.line_word_select;
        v_store = {32'b0, if2.hmem_req_store_data}; v_lwd = {32'b0, if2.line_write_data};
      end
      3: begin
        v_valid = if3.hmem_req_valid; v_wr = if3.hmem_req_write; v_lw = if3.line_write;
        v_cv = if3.critical_valid; v_done = if3.done; v_addr = if3.hmem_req_address;
        v_cw = if3.critical_word; v_wsel = if3.line_word_select;
        v_store = {32'b0, if3.hmem_req_store_data}; v_lwd = {32'b0, if3.line_write_data};
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  wsel;
    logic        wr;
    logic        crit;
    logic [31:0] cw;
    logic        two;
  } beat_t;
  beat_t exp_q[$];
  int    exp_done[$];

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name);
    total++;
    bad++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (v_valid) begin
      if (exp_q.size() == 0) fail("unexpected_req");
      else begin
        beat_t e;
        e = exp_q[0];
        check("req_addr", v_addr, e.addr);
        check("word_sel", v_wsel, e.wsel);
        check("req_write", v_wr, e.wr);
        if (e.wr)
          check("store_data", v_store, e.two ? {line_word(e.wsel + 3'd1), line_word(e.wsel)}
                                             : {32'b0, line_word(e.wsel)});
        if (fulfilled) begin
          check("line_write", v_lw, !e.wr);
          check("crit_valid", v_cv, e.crit);
          if (!e.wr)
            check("line_data", v_lwd, e.two ? {mem_word(e.addr + 32'd4), mem_word(e.addr)}
                                            : {32'b0, mem_word(e.addr)});
          if (e.crit) check("crit_word", v_cw, e.cw);
          void'(exp_q.pop_front());
        end else begin
          check("stall_line_write", v_lw, 1'b0);
          check("stall_crit_valid", v_cv, 1'b0);
        end
      end
    end else begin
      check("idle_line_write", v_lw, 1'b0);
      check("idle_crit_valid", v_cv, 1'b0);
    end
    if (v_done) begin
      if (exp_done.size() == 0) fail("spurious_done");
      else check("done_cycle", cyc, exp_done.pop_front());
    end else if (exp_done.size() > 0 && cyc > exp_done[0]) begin
      check("done_missing", cyc, exp_done.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] a, logic [2:0] w, logic wr, logic cr, logic [31:0] cw, logic two);
    beat_t b;
    b.addr = a; b.wsel = w; b.wr = wr; b.crit = cr; b.cw = cw; b.two = two;
    exp_q.push_back(b);
  endtask

  // called just after a rising edge with the target idle; lat = cycles from
  // the accept edge to the done cycle minus one (BEATS for zero-wait)
  task automatic issue(int s, logic wb, logic [31:0] a, int lat);
    sel = s;
    cmd_writeback = wb;
    cmd_address = a;
    cmd_valid = 1'b1;
    exp_done.push_back(cyc + 1 + lat);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_fill_1234_cf();
    push(32'h1230, 3'd4, 1'b0, 1'b1, mem_word(32'h1234), 1'b1);
    push(32'h1238, 3'd6, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h1220, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h1228, 3'd2, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic push_fill_2008_cf();
    push(32'h2008, 3'd2, 1'b0, 1'b1, mem_word(32'h2008), 1'b1);
    push(32'h2010, 3'd4, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h2018, 3'd6, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h2000, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    int c0;
    reset = 1'b1; sel = 0; cmd_valid = 0; cmd_writeback = 0; cmd_address = 0; fulfilled = 0;
    #2;
    check("rst_cmd_ready", if0.cmd_ready, 1'b1);
    check("rst_busy", if0.busy, 1'b0);
    check("rst_done", if0.done, 1'b0);
    check("rst_req_valid", if0.hmem_req_valid, 1'b0);
    check("rst_req_write", if0.hmem_req_write, 1'b0);
    check("rst_line_write", if0.line_write, 1'b0);
    check("rst_req_addr", if0.hmem_req_address, 32'h0);
    check("rst_word_sel", if0.line_word_select, 3'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // critical-first fill, zero wait (fulfilled already high in idle)
    fulfilled = 1'b1;
    push_fill_1234_cf();
    issue(0, 1'b0, 32'h0000_1234, 4);
    repeat (8) tick();

    // in-order fill: requested word arrives on the third beat
    push(32'h1220, 3'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h1228, 3'd2, 1'b0, 1'b0, 32'h0, 1'b1);
    push(32'h1230, 3'd4, 1'b0, 1'b1, mem_word(32'h1234), 1'b1);
    push(32'h1238, 3'd6, 1'b0, 1'b0, 32'h0, 1'b1);
    issue(1, 1'b0, 32'h0000_1234, 4);
    repeat (8) tick();

    // writeback with fulfilled only every third cycle
    fulfilled = 1'b0;
    for (int w = 0; w < 8; w++) push(32'h4000 + 32'(w) * 4, 3'(w), 1'b1, 1'b0, 32'h0, 1'b0);
    issue(2, 1'b1, 32'h0000_4000, 24);
    for (int k = 0; k < 24; k++) begin
      fulfilled = (k % 3 == 2);
      tick();
    end
    fulfilled = 1'b0;
    repeat (4) tick();

    // reset after two beats of a fill, then a clean fill
    fulfilled = 1'b1;
    push_fill_1234_cf();
    issue(0, 1'b0, 32'h0000_1234, 4);
    repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    exp_done.delete();
    #1;
    check("mid_rst_cmd_ready", if0.cmd_ready, 1'b1);
    check("mid_rst_busy", if0.busy, 1'b0);
    check("mid_rst_req_valid", if0.hmem_req_valid, 1'b0);
    check("mid_rst_line_write", if0.line_write, 1'b0);
    check("mid_rst_crit_valid", if0.critical_valid, 1'b0);
    check("mid_rst_done", if0.done, 1'b0);
    check("mid_rst_req_addr", if0.hmem_req_address, 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    push_fill_2008_cf();
    issue(0, 1'b0, 32'h0000_2008, 4);
    repeat (8) tick();

    // read-only instance: writeback completes with no memory traffic
    issue(3, 1'b1, 32'h0000_4000, 0);
    repeat (6) tick();

    // cmd_valid held through a fill; address change mid-fill is ignored
    sel = 0;
    push_fill_1234_cf();
    push_fill_2008_cf();
    cmd_writeback = 1'b0;
    cmd_address = 32'h0000_1234;
    cmd_valid = 1'b1;
    c0 = cyc;
    exp_done.push_back(c0 + 5);
    exp_done.push_back(c0 + 11);
    tick();
    cmd_address = 32'h0000_2008;
    repeat (6) tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    fulfilled = 1'b0;
    repeat (2) tick();

    check("beats_left", exp_q.size(), 0);
    check("dones_left", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
